digit_entry_ctrl: RTL and testbench

Parametrised successor to the fixed 4-digit MM:SS time-set block. Provides cursor-driven BCD entry over `NUM_DIGITS` digits with a per-digit upper bound, auto-repeat on held up/down, preload, and a done/ack handshake. Sits between the debounced push-button/switch inputs and the 7-segment driver/countdown core. Feeds the driver with `value` and the `sel` digit mask, and feeds the countdown core with `value` and `done`.

---
 rtl/digit_entry_pkg.sv | 22 ++
 rtl/digit_entry_ctrl_key_repeat.sv | 56 +++++
 rtl/digit_entry_ctrl.sv | 155 +++++++++++++++
 tb/tb_digit_entry_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and helpers for the cursor-driven BCD digit entry block.
package digit_entry_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StEdit,
        StDone
    } state_e;

    function automatic logic [DIGIT_W-1:0] digit_max(input logic [31:0] max_vec,
                                                     input int unsigned idx);
        return max_vec[idx*DIGIT_W +: DIGIT_W];
    endfunction

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] val,
                                                       input logic [DIGIT_W-1:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/digit_entry_ctrl_key_repeat.sv
// Press-edge detection plus auto-repeat for a held button: one step on the edge,
// one after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles while held.
module key_repeat #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic step
);

    localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned CntW      = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] DelayCnt  = CntW'(REPEAT_DELAY);
    localparam logic [CntW-1:0] PeriodCnt = CntW'(REPEAT_PERIOD);

    logic            level_q;
    logic            rep_q, rep_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        step  = 1'b0;
        cnt_d = cnt_q;
        rep_d = rep_q;
        if (!level) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!level_q) begin
            step  = 1'b1;
            cnt_d = CntW'(1);
            rep_d = 1'b0;
        end else if ((!rep_q && cnt_q == DelayCnt) || (rep_q && cnt_q == PeriodCnt)) begin
            // cnt_q counts cycles since the last step, so reload to 1 on every step
            step  = 1'b1;
            cnt_d = CntW'(1);
            rep_d = 1'b1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Cursor-driven BCD entry over NUM_DIGITS digits with per-digit bound, auto-repeat,
// preload and a done/ack handshake towards the countdown core.
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter logic [31:0] DIGIT_MAX     = 32'h0000_5959,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          edit_en,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    input  logic                          ack,
    output logic [NUM_DIGITS-1:0]         sel,
    output logic [DIGIT_W*NUM_DIGITS-1:0] value,
    output logic                          done
);

    localparam int unsigned CurW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ValW = DIGIT_W * NUM_DIGITS;
    localparam logic [CurW-1:0] CurTop = CurW'(NUM_DIGITS - 1);

    state_e            state_q, state_d;
    logic [CurW-1:0]   cur_q, cur_d;
    logic [ValW-1:0]   value_q, value_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic              done_q, done_d;

    logic edit_q, left_q, right_q, armed_q;
    logic edit_rise, edit_fall, left_rise, right_rise;
    logic up_step, down_step;
    logic [DIGIT_W-1:0] cur_digit, cur_max, new_digit;

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_up (
        .clk   (clk),
        .reset (reset),
        .level (btn_up),
        .step  (up_step)
    );

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_down (
        .clk   (clk),
        .reset (reset),
        .level (btn_down),
        .step  (down_step)
    );

    // armed_q blocks a rise when edit_en was already high as reset released
    assign edit_rise  = edit_en & ~edit_q & armed_q;
    assign edit_fall  = ~edit_en & edit_q;
    assign left_rise  = btn_left & ~left_q;
    assign right_rise = btn_right & ~right_q;

    assign cur_digit = value_q[int'(cur_q)*DIGIT_W +: DIGIT_W];
    assign cur_max   = digit_max(DIGIT_MAX, int'(cur_q));

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        value_d   = value_q;
        new_digit = cur_digit;
        unique case (state_q)
            StIdle: begin
                if (edit_rise) begin
                    state_d = StEdit;
                    cur_d   = CurTop;
                end
            end
            StEdit: begin
                if (edit_fall) begin
                    state_d = StDone;
                end else if (left_rise != right_rise) begin
                    if (left_rise) begin
                        cur_d = (cur_q == CurTop) ? '0 : cur_q + 1'b1;
                    end else begin
                        cur_d = (cur_q == '0) ? CurTop : cur_q - 1'b1;
                    end
                end else if (up_step != down_step) begin
                    if (up_step) begin
                        new_digit = (cur_digit >= cur_max) ? '0 : cur_digit + 1'b1;
                    end else begin
                        new_digit = (cur_digit == '0) ? cur_max : cur_digit - 1'b1;
                    end
                    value_d[int'(cur_q)*DIGIT_W +: DIGIT_W] = new_digit;
                end
            end
            StDone: begin
                if (edit_rise) begin
                    state_d = StEdit;
                    cur_d   = CurTop;
                end else if (ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load && state_q != StEdit) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                value_d[d*DIGIT_W +: DIGIT_W] =
                    clamp_digit(load_value[d*DIGIT_W +: DIGIT_W], digit_max(DIGIT_MAX, d));
            end
        end

        sel_d  = '0;
        done_d = (state_d == StDone);
        if (state_d == StEdit) begin
            sel_d[cur_d] = 1'b1;
        end else if (state_d == StDone) begin
            sel_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cur_q   <= CurTop;
            value_q <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            edit_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            armed_q <= ~edit_en;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            value_q <= value_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            edit_q  <= edit_en;
            left_q  <= btn_left;
            right_q <= btn_right;
            armed_q <= armed_q | ~edit_en;
        end
    end

    assign sel   = sel_q;
    assign value = value_q;
    assign done  = done_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl with short repeat timing (delay 4, period 2).
`timescale 1ns/1ps
module tb_digit_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        edit_en, btn_up, btn_down, btn_left, btn_right, load, ack;
    logic [15:0] load_value;
    logic [3:0]  sel;
    logic [15:0] value;
    logic        done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    digit_entry_ctrl #(
        .NUM_DIGITS    (4),
        .DIGIT_MAX     (32'h0000_5959),
        .REPEAT_DELAY  (4),
        .REPEAT_PERIOD (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .edit_en    (edit_en),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .load       (load),
        .load_value (load_value),
        .ack        (ack),
        .sel        (sel),
        .value      (value),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // inputs change on the falling edge, outputs are sampled on the next falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        {edit_en, btn_up, btn_down, btn_left, btn_right, load, ack} = '0;
        load_value = '0;
        cyc(2);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_value", 32'(value), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        cyc(1);

        edit_en = 1'b1;
        cyc(1);
        check("enter_sel", 32'(sel), 32'h8);
        check("enter_value", 32'(value), 32'h0);
        check("enter_done", 32'(done), 32'h0);

        for (int i = 1; i <= 6; i++) begin
            btn_up = 1'b1;
            cyc(1);
            btn_up = 1'b0;
            check("up_pulse_d3", 32'(value), 32'((i % 6) << 12));
            cyc(1);
        end

        btn_left = 1'b1;
        cyc(1);
        btn_left = 1'b0;
        check("left_wrap", 32'(sel), 32'h1);
        cyc(1);

        btn_down = 1'b1;
        cyc(1);
        btn_down = 1'b0;
        check("down_wrap_d0", 32'(value), 32'h0009);
        cyc(1);

        btn_up = 1'b1;
        cyc(1);
        btn_up = 1'b0;
        check("up_wrap_d0", 32'(value), 32'h0000);
        cyc(1);

        btn_up = 1'b1;
        cyc(1);
        check("hold_edge", 32'(value), 32'h0001);
        cyc(4);
        check("hold_delay", 32'(value), 32'h0002);
        cyc(6);
        check("hold_end", 32'(value), 32'h0005);
        btn_up = 1'b0;
        cyc(3);
        check("hold_release", 32'(value), 32'h0005);

        btn_left = 1'b1;
        btn_up   = 1'b1;
        cyc(1);
        check("left_up_sel", 32'(sel), 32'h2);
        check("left_up_value", 32'(value), 32'h0005);
        {btn_left, btn_up} = '0;
        cyc(1);

        btn_left  = 1'b1;
        btn_right = 1'b1;
        cyc(1);
        check("left_right_sel", 32'(sel), 32'h2);
        {btn_left, btn_right} = '0;
        cyc(1);

        btn_up   = 1'b1;
        btn_down = 1'b1;
        cyc(1);
        check("up_down_value", 32'(value), 32'h0005);
        {btn_up, btn_down} = '0;
        cyc(1);

        btn_down = 1'b1;
        cyc(1);
        btn_down = 1'b0;
        check("down_wrap_d1", 32'(value), 32'h0055);
        cyc(1);

        edit_en = 1'b0;
        cyc(1);
        check("done_flag", 32'(done), 32'h1);
        check("done_sel", 32'(sel), 32'hf);
        check("done_value", 32'(value), 32'h0055);

        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        check("ack_done", 32'(done), 32'h0);
        check("ack_sel", 32'(sel), 32'h0);
        cyc(1);

        load       = 1'b1;
        load_value = 16'h9999;
        cyc(1);
        load = 1'b0;
        check("load_clamp", 32'(value), 32'h5959);
        check("load_idle_sel", 32'(sel), 32'h0);

        edit_en = 1'b1;
        cyc(1);
        check("reenter_sel", 32'(sel), 32'h8);
        load       = 1'b1;
        load_value = 16'h1234;
        cyc(1);
        load = 1'b0;
        check("load_in_edit", 32'(value), 32'h5959);

        edit_en = 1'b0;
        cyc(1);
        check("done2_flag", 32'(done), 32'h1);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("load_in_done", 32'(value), 32'h1234);
        check("load_keeps_done", 32'(done), 32'h1);

        edit_en = 1'b1;
        ack     = 1'b1;
        cyc(1);
        ack = 1'b0;
        check("edit_beats_ack_sel", 32'(sel), 32'h8);
        check("edit_beats_ack_done", 32'(done), 32'h0);

        btn_up = 1'b1;
        cyc(2);
        check("pre_reset_value", 32'(value), 32'h2234);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_value", 32'(value), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        btn_up = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        check("no_edge_after_rst", 32'(sel), 32'h0);

        edit_en = 1'b0;
        cyc(1);
        edit_en = 1'b1;
        cyc(1);
        check("edge_after_rearm", 32'(sel), 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
